wb_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline's writeback and out-of-band load responses from the LSU. It drives the select of the 4:1 writeback mux, plus the register-file write enable and address. A 2-entry load-return buffer absorbs LSU responses, which cannot be back-pressured. A pending-destination mask lets hazard logic stall readers of registers whose loads have not yet been written.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_load_fifo.sv | 76 +++++++
 rtl/wb_arbiter.sv | 95 +++++++++
 tb/tb_wb_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback encodings and the load-return entry type.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_CSR  = 2'b11
  } wb_src_e;

  localparam int WB_WIDTH      = 32;
  localparam int WB_REG_ADDR_W = 5;

  // Load-return entry at the default register-file geometry.
  typedef struct packed {
    logic [WB_REG_ADDR_W-1:0] rd;
    logic [WB_WIDTH-1:0]      data;
  } wb_load_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Two-entry load-return FIFO; exposes per-slot valid and rd so the parent can build the pending mask.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [REG_ADDR_W-1:0]      push_rd,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [REG_ADDR_W-1:0]      head_rd,
  output logic [WIDTH-1:0]           head_data,
  output logic [1:0]                 slot_vld,
  output logic [1:0][REG_ADDR_W-1:0] slot_rd
);

  logic [1:0][REG_ADDR_W-1:0] rd_q, rd_d;
  logic [1:0][WIDTH-1:0]      data_q, data_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic                       push_ok, pop_ok;

  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);
  assign head_rd   = rd_q[rd_ptr_q];
  assign head_data = empty ? '0 : data_q[rd_ptr_q];
  assign slot_rd   = rd_q;

  // A push while full is legal only because the parent always pops when full.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      rd_d[wr_ptr_q]   = push_rd;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop_ok) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_comb begin
    slot_vld = '0;
    for (int i = 0; i < 2; i++) begin
      slot_vld[i] = full || ((cnt_q == 2'd1) && (rd_ptr_q == 1'(i)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      data_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      rd_q     <= rd_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and buffered LSU load returns.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_valid,
  input  logic [REG_ADDR_W-1:0]    pipe_rd,
  input  logic [1:0]               pipe_src,
  output logic                     pipe_ready,
  input  logic                     lsu_valid,
  input  logic [REG_ADDR_W-1:0]    lsu_rd,
  input  logic [WIDTH-1:0]         lsu_data,
  output logic [1:0]               wb_sel,
  output logic [WIDTH-1:0]         wb_load_data,
  output logic                     rf_we,
  output logic [REG_ADDR_W-1:0]    rf_waddr,
  output logic [2**REG_ADDR_W-1:0] pend_mask
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic                       push, pop;
  logic                       full, empty, pipe_wins;
  logic [REG_ADDR_W-1:0]      head_rd;
  logic [1:0]                 slot_vld;
  logic [1:0][REG_ADDR_W-1:0] slot_rd;
  logic [SW-1:0]              starve_q, starve_d;

  assign push = lsu_valid && (lsu_rd != '0);

  wb_load_fifo #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head_rd   (head_rd),
    .head_data (wb_load_data),
    .slot_vld  (slot_vld),
    .slot_rd   (slot_rd)
  );

  // With a single buffered load the pipeline may take the port once it has waited long enough.
  assign pipe_wins = empty || (!full && (starve_q == STARVE_MAX));

  always_comb begin
    pop        = 1'b0;
    wb_sel     = WB_ALU;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    pipe_ready = 1'b0;
    if (!pipe_wins) begin
      pop      = 1'b1;
      wb_sel   = WB_LOAD;
      rf_we    = 1'b1;
      rf_waddr = head_rd;
    end else begin
      pipe_ready = 1'b1;
      if (pipe_valid) begin
        wb_sel   = pipe_src;
        rf_waddr = pipe_rd;
        rf_we    = (pipe_rd != '0);
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!pipe_valid || pipe_ready) starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < 2; i++) begin
      if (slot_vld[i]) pend_mask[slot_rd[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [1:0]  pipe_src = '0;
  logic        pipe_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic [1:0]  wb_sel;
  logic [31:0] wb_load_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] pend_mask;

  wb_arbiter #(.WIDTH(32), .REG_ADDR_W(5), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_valid   (pipe_valid),
    .pipe_rd      (pipe_rd),
    .pipe_src     (pipe_src),
    .pipe_ready   (pipe_ready),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .wb_sel       (wb_sel),
    .wb_load_data (wb_load_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .pend_mask    (pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   starve = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic        s_ready, s_we;
  logic [1:0]  s_sel;
  logic [4:0]  s_waddr;
  logic [31:0] s_ldata, s_pend;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare outputs to the model, then advance the model at the edge.
  task automatic cycle(input logic pv, input logic [4:0] prd, input logic [1:0] psrc,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bit          pw;
    logic        e_ready, e_we;
    logic [1:0]  e_sel;
    logic [4:0]  e_waddr;
    logic [31:0] e_ldata, e_pend;
    @(negedge clk);
    pipe_valid = pv; pipe_rd = prd; pipe_src = psrc;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    pw = (q.size() == 0) || (q.size() == 1 && starve == LIMIT);
    e_ready = pw; e_we = 0; e_sel = 2'b00; e_waddr = 0;
    if (!pw) begin
      e_we = 1; e_sel = 2'b01; e_waddr = q[0].rd;
    end else if (pv) begin
      e_we = (prd != 0); e_sel = psrc; e_waddr = prd;
    end
    e_ldata = (q.size() > 0) ? q[0].data : 32'h0;
    e_pend = 0;
    foreach (q[i]) e_pend[q[i].rd] = 1'b1;
    e_pend[0] = 1'b0;
    s_ready = pipe_ready; s_we = rf_we; s_sel = wb_sel; s_waddr = rf_waddr;
    s_ldata = wb_load_data; s_pend = pend_mask;
    chk("pipe_ready", 64'(pipe_ready), 64'(e_ready));
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("wb_sel", 64'(wb_sel), 64'(e_sel));
    chk("rf_waddr", 64'(rf_waddr), 64'(e_waddr));
    chk("wb_load_data", 64'(wb_load_data), 64'(e_ldata));
    chk("pend_mask", 64'(pend_mask), 64'(e_pend));
    @(posedge clk);
    if (!pw) q.delete(0);
    if (lv && lrd != 0) q.push_back('{rd: lrd, data: ld});
    if (q.size() > 2) chk("model_depth", 64'(q.size()), 64'd2);
    if (!pv || pw) starve = 0;
    else if (starve < LIMIT) starve++;
  endtask

  initial begin
    logic        hold_pv;
    logic [4:0]  hold_rd;
    logic [1:0]  hold_src;
    logic [1:0]  srcs [3];
    logic        stall_exp [5];
    srcs[0] = 2'b00; srcs[1] = 2'b10; srcs[2] = 2'b11;
    stall_exp[0] = 0; stall_exp[1] = 0; stall_exp[2] = 0; stall_exp[3] = 0; stall_exp[4] = 1;

    #12;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_wb_sel", 64'(wb_sel), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_load_data", 64'(wb_load_data), 64'd0);
    chk("rst_pend", 64'(pend_mask), 64'd0);
    chk("rst_ready", 64'(pipe_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Pipeline writeback with empty buffer: zero latency.
    cycle(1, 5'd5, 2'b00, 0, 0, 0);
    chk("t1_ready", 64'(s_ready), 64'd1);
    chk("t1_we", 64'(s_we), 64'd1);
    chk("t1_waddr", 64'(s_waddr), 64'd5);
    chk("t1_sel", 64'(s_sel), 64'd0);

    // Single load, pipe idle.
    cycle(0, 0, 0, 1, 5'd7, 32'hDEADBEEF);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t2_pend7", 64'(s_pend[7]), 64'd1);
    chk("t2_we", 64'(s_we), 64'd1);
    chk("t2_waddr", 64'(s_waddr), 64'd7);
    chk("t2_sel", 64'(s_sel), 64'd1);
    chk("t2_data", 64'(s_ldata), 64'hDEADBEEF);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t2_pend_clear", 64'(s_pend), 64'd0);

    // Back-to-back loads with pipeline waiting on rd 9.
    cycle(0, 0, 0, 1, 5'd3, 32'h33);
    cycle(1, 5'd9, 2'b10, 1, 5'd4, 32'h44);
    chk("t3_a_waddr", 64'(s_waddr), 64'd3);
    chk("t3_a_ready", 64'(s_ready), 64'd0);
    cycle(1, 5'd9, 2'b10, 0, 0, 0);
    chk("t3_b_waddr", 64'(s_waddr), 64'd4);
    chk("t3_b_ready", 64'(s_ready), 64'd0);
    cycle(1, 5'd9, 2'b10, 0, 0, 0);
    chk("t3_c_waddr", 64'(s_waddr), 64'd9);
    chk("t3_c_ready", 64'(s_ready), 64'd1);
    chk("t3_c_sel", 64'(s_sel), 64'd2);

    // Starvation override with one entry kept buffered.
    cycle(0, 0, 0, 1, 5'd11, 32'h1100);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 5'd10, 2'b00, 1, 5'(12 + i), 32'h1200 + 32'(i));
      chk("t4_ready", 64'(s_ready), 64'(stall_exp[i]));
    end

    // Full buffer with continuous loads: load written every cycle, pipe stalled.
    for (int i = 0; i < 6; i++) begin
      cycle(1, 5'd20, 2'b11, 1, 5'(21 + i), 32'h2100 + 32'(i));
      chk("t5_ready", 64'(s_ready), 64'd0);
      chk("t5_we", 64'(s_we), 64'd1);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);

    // Loads to x0 are dropped; pipe write to x0 suppresses rf_we.
    cycle(0, 0, 0, 1, 5'd0, 32'hFFFF);
    cycle(0, 0, 0, 1, 5'd0, 32'hEEEE);
    chk("t6_we", 64'(s_we), 64'd0);
    chk("t6_pend", 64'(s_pend), 64'd0);
    cycle(1, 5'd0, 2'b00, 0, 0, 0);
    chk("t6_ready", 64'(s_ready), 64'd1);
    chk("t6_we_x0", 64'(s_we), 64'd0);

    // Randomized traffic; pipeline holds its request while stalled.
    hold_pv = 0; hold_rd = 0; hold_src = 0;
    for (int n = 0; n < 3000; n++) begin
      logic       lv, stalled;
      logic [4:0] lrd;
      stalled = hold_pv && !s_ready;
      if (!stalled) begin
        hold_pv  = ($urandom_range(0, 3) != 0);
        hold_rd  = 5'($urandom_range(0, 31));
        hold_src = srcs[$urandom_range(0, 2)];
      end
      lv  = ($urandom_range(0, 99) < 55);
      lrd = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      cycle(hold_pv, hold_rd, hold_src, lv, lrd, $urandom);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);

    // Reset in the middle of buffered traffic.
    cycle(0, 0, 0, 1, 5'd6, 32'h6);
    cycle(1, 5'd8, 2'b00, 1, 5'd9, 32'h9);
    cycle(0, 0, 0, 1, 5'd13, 32'hD);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t7_pend13", 64'(s_pend[13]), 64'd1);
    @(negedge clk);
    cycle_prep_done: begin
      pipe_valid = 0; lsu_valid = 0;
      #2 rst = 1'b1;
      #1;
      chk("t7_pend_rst", 64'(pend_mask), 64'd0);
      chk("t7_we_rst", 64'(rf_we), 64'd0);
      chk("t7_ready_rst", 64'(pipe_ready), 64'd1);
      chk("t7_data_rst", 64'(wb_load_data), 64'd0);
    end
    q.delete();
    starve = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 5'd2, 2'b10, 0, 0, 0);
    chk("t7_post_ready", 64'(s_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
